// File: rtl/button_pkg.sv
// button_pkg: shared defaults and width helper for the button conditioner.
// Imported by button_channel and button_conditioner.
package button_pkg;

  localparam int DEF_NUM_CH          = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_LONG_CYCLES     = 16;

  // Bits needed to hold any value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// button_channel: one button path -- sync, debounce, edge pulses and
// an optional long-press detector enabled by BTN_LONGPRESS_EN.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic reset_async,
  input  logic button_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_param
    $error("button_channel: cycle parameters must be >= 1");
  end

  logic          sync_d;
  logic          sync_q;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the raw asynchronous button level.
  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      sync_d <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sync_d <= button_i;
      sync_q <= sync_d;
    end
  end

  // Accept a level change after enough consecutive mismatches.
  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      cnt       <= '0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      press_o   <= 1'b0;
      release_o <= 1'b0;
      if (sync_q == level_o) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt       <= '0;
        level_o   <= ~level_o;
        press_o   <= ~level_o;
        release_o <= level_o;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef BTN_LONGPRESS_EN
  localparam int HW = cnt_width(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] hold;

  // Saturating hold timer; fires once when it first reaches the limit.
  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      hold   <= '0;
      long_o <= 1'b0;
    end else begin
      long_o <= 1'b0;
      if (!level_o) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold   <= hold + HW'(1);
        long_o <= (hold == HOLD_MAX - HW'(1));
      end
    end
  end
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: NUM_CH independent debounced button channels.
// Long-press pulses are built only when BTN_LONGPRESS_EN is defined.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic              clk,
  input  logic              reset_async,
  input  logic [NUM_CH-1:0] buttons_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] press_o,
  output logic [NUM_CH-1:0] release_o,
  output logic [NUM_CH-1:0] long_o
);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
    $error("button_conditioner: NUM_CH must be 1..16");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset_async(reset_async),
      .button_i   (buttons_i[i]),
      .level_o    (level_o[i]),
      .press_o    (press_o[i]),
      .release_o  (release_o[i]),
      .long_o     (long_o[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random stimulus checked
// against a sample-window reference model of the debouncer.
module tb_button_conditioner;

  localparam int NC = 2;
  localparam int DB = 4;
  localparam int LC = 16;

  logic          clk;
  logic          reset_async;
  logic [NC-1:0] buttons_i;
  logic [NC-1:0] level_o;
  logic [NC-1:0] press_o;
  logic [NC-1:0] release_o;
  logic [NC-1:0] long_o;

  button_conditioner #(
    .NUM_CH         (NC),
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LC)
  ) dut (
    .clk        (clk),
    .reset_async(reset_async),
    .buttons_i  (buttons_i),
    .level_o    (level_o),
    .press_o    (press_o),
    .release_o  (release_o),
    .long_o     (long_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: level flips at edge t when the DB most recent
  // synchronized samples (raw samples t-2 .. t-1-DB) all differ
  // from the level and all of those edges came after the last flip.
  int t;
  int tlast [NC];
  bit lvl   [NC];
  bit ring  [NC][64];
  bit e_lvl [NC];
  bit e_prs [NC];
  bit e_rel [NC];
  bit e_lng [NC];

  int  prs_n [NC];
  int  rel_n [NC];
  int  lng_n [NC];
  bit  saw_both;

  function automatic bit raw_at(input int c, input int idx);
    return (idx < 0) ? 1'b0 : ring[c][idx % 64];
  endfunction

  task automatic model_reset();
    t = 0;
    for (int c = 0; c < NC; c++) begin
      tlast[c] = -1;
      lvl[c]   = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [NC-1:0] v);
    for (int c = 0; c < NC; c++) begin
      bit cur;
      bit tog;
      ring[c][t % 64] = v[c];
      cur = lvl[c];
      tog = 1'b1;
      for (int k = 0; k < DB; k++) begin
        if ((t - k) <= tlast[c]) tog = 1'b0;
        if (raw_at(c, t - 2 - k) == cur) tog = 1'b0;
      end
`ifdef BTN_LONGPRESS_EN
      e_lng[c] = cur && ((t - tlast[c]) == LC);
`else
      e_lng[c] = 1'b0;
`endif
      e_prs[c] = tog && !cur;
      e_rel[c] = tog && cur;
      if (tog) begin
        lvl[c]   = !cur;
        tlast[c] = t;
      end
      e_lvl[c] = lvl[c];
    end
    t++;
  endtask

  task automatic chk(input string tag, input int ch,
                     input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s ch%0d got=%0b exp=%0b", tag, ch, got, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int got,
                       input int exp);
    total++;
    assert (got == exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    for (int c = 0; c < NC; c++) begin
      prs_n[c] = 0;
      rel_n[c] = 0;
      lng_n[c] = 0;
    end
    saw_both = 1'b0;
  endtask

  task automatic step(input logic [NC-1:0] v);
    buttons_i = v;
    @(posedge clk);
    model_edge(v);
    #1;
    for (int c = 0; c < NC; c++) begin
      chk("level", c, level_o[c], e_lvl[c]);
      chk("press", c, press_o[c], e_prs[c]);
      chk("release", c, release_o[c], e_rel[c]);
      chk("long", c, long_o[c], e_lng[c]);
      prs_n[c] += int'(press_o[c]);
      rel_n[c] += int'(release_o[c]);
      lng_n[c] += int'(long_o[c]);
    end
    if (press_o == 2'b11) saw_both = 1'b1;
  endtask

  task automatic hold(input logic [NC-1:0] v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic do_reset(input int cycles);
    reset_async = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) begin
      chk("rst_level", c, level_o[c], 1'b0);
      chk("rst_press", c, press_o[c], 1'b0);
      chk("rst_release", c, release_o[c], 1'b0);
      chk("rst_long", c, long_o[c], 1'b0);
    end
    repeat (cycles) @(posedge clk);
    #1;
    for (int c = 0; c < NC; c++) begin
      chk("rst_hold_level", c, level_o[c], 1'b0);
      chk("rst_hold_press", c, press_o[c], 1'b0);
    end
    @(negedge clk);
    reset_async = 1'b1;
    model_reset();
  endtask

  int run_len [NC];
  logic [NC-1:0] rv;
  int exp_long;

  initial begin
    reset_async = 1'b1;
    buttons_i   = '0;
    model_reset();
    clr_counts();
`ifdef BTN_LONGPRESS_EN
    exp_long = 1;
`else
    exp_long = 0;
`endif
    #2;
    do_reset(2);

    hold(2'b00, 10);

    clr_counts();
    hold(2'b01, 10);
    chk_n("stable_press_cnt", prs_n[0], 1);
    hold(2'b00, 10);
    chk_n("stable_release_cnt", rel_n[0], 1);

    clr_counts();
    hold(2'b01, 2);
    hold(2'b00, 10);
    chk_n("glitch_press_cnt", prs_n[0], 0);
    chk_n("glitch_release_cnt", rel_n[0], 0);

    clr_counts();
    hold(2'b01, 3);
    hold(2'b00, 1);
    hold(2'b01, 8);
    chk_n("chatter_press_cnt", prs_n[0], 1);
    hold(2'b00, 10);

    clr_counts();
    hold(2'b01, 30);
    hold(2'b00, 10);
    chk_n("long_cnt", lng_n[0], exp_long);
    chk_n("long_press_cnt", prs_n[0], 1);
    chk_n("long_release_cnt", rel_n[0], 1);

    hold(2'b01, 4);
    do_reset(1);
    clr_counts();
    hold(2'b01, 8);
    chk_n("rst_mid_press_cnt", prs_n[0], 1);
    hold(2'b00, 10);

    clr_counts();
    hold(2'b11, 10);
    hold(2'b01, 3);
    hold(2'b00, 10);
    chk_n("indep_both_press", int'(saw_both), 1);
    chk_n("indep_rel0_cnt", rel_n[0], 1);
    chk_n("indep_rel1_cnt", rel_n[1], 1);

    for (int c = 0; c < NC; c++) run_len[c] = 0;
    rv = '0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(2);
      for (int c = 0; c < NC; c++) begin
        if (run_len[c] == 0) begin
          rv[c] = ~rv[c];
          if ($urandom_range(0, 5) == 0)
            run_len[c] = $urandom_range(17, 30);
          else
            run_len[c] = $urandom_range(1, 8);
        end
        run_len[c]--;
      end
      step(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent button channels, 1..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive mismatching cycles needed to accept a level change, minimum 1.
REQ-003 Parameter LONG_CYCLES, default 16: cycles of accepted high level that signal a long press, minimum 1.
REQ-004 Port clk, input, 1: single clock; all state is rising-edge.
REQ-005 Port reset_async, input, 1: reset, asynchronous and active-low.
REQ-006 Port buttons_i, input, NUM_CH: raw button levels, asynchronous to clk, 1 = pressed.
REQ-007 Port level_o, output, NUM_CH: debounced, registered level per channel.
REQ-008 Port press_o, output, NUM_CH: one-cycle pulse on an accepted 0->1 of level_o.
REQ-009 Port release_o, output, NUM_CH: one-cycle pulse on an accepted 1->0 of level_o.
REQ-010 Port long_o, output, NUM_CH: one-cycle long-press pulse (see Configuration).

Function
REQ-011 Each channel passes through a 2-flop synchronizer; sync_q is the second-flop output.
REQ-012 Per-channel counter, width clog2(DEBOUNCE_CYCLES+1): increments on each edge where sync_q != level_o and clears on each edge where they are equal.
REQ-013 On an edge where sync_q != level_o and the counter equals DEBOUNCE_CYCLES-1, level_o toggles and the counter clears.
REQ-014 Latency: raw level first sampled at edge N and held stable thereafter -> level_o changes at edge N+1+DEBOUNCE_CYCLES.
REQ-015 Any equal cycle before the threshold restarts the count; a glitch lasting fewer than DEBOUNCE_CYCLES synchronized cycles never changes level_o.
REQ-016 press_o/release_o are registered at the same edge as the level_o toggle, are high for exactly one cycle, and never coincide on one channel.
REQ-017 Channels are fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
REQ-018 The counter never wraps: its maximum value is DEBOUNCE_CYCLES-1.

Reset
REQ-019 While reset_async is low: synchronizer, counters, hold counters, level_o, press_o, release_o and long_o are all 0.
REQ-020 Reset asserted mid-debounce or mid-hold discards the partial count; no pulse is emitted on entry to or exit from reset.
REQ-021 A button already held at reset release is accepted as a normal press, with press_o asserted per REQ-014 counted from the first edge after release.

Configuration
REQ-022 Macro BTN_LONGPRESS_EN defined: each channel has a saturating hold counter that counts edges while level_o=1 and clears when level_o=0.
REQ-023 With BTN_LONGPRESS_EN: long_o pulses for one cycle when the hold counter reaches LONG_CYCLES; at most one long_o pulse per press; a release before LONG_CYCLES gives no long_o.
REQ-024 Without BTN_LONGPRESS_EN: no hold counters are built and long_o is tied to constant 0; all other behaviour is identical.

Structure
REQ-025 Package button_pkg holds the default parameter constants and the counter-width helper function.
REQ-026 Sub-module button_channel implements one channel (synchronizer, debounce, edge pulses, optional hold) and is instantiated NUM_CH times by a generate loop.
REQ-027 The top level contains no state beyond the button_channel instances.

Verification (NUM_CH=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=16, 10 ns clock)
REQ-028 Stable press: buttons_i[0]=1 from edge 10 -> level_o[0]=1 and press_o[0]=1 after edge 15; press_o[0] low again after edge 16.
REQ-029 Glitch: buttons_i[0] high for 2 cycles -> level_o, press_o and release_o stay 0 throughout.
REQ-030 Chatter: 1,1,1,0,1,1,1,1 pattern -> exactly one press_o pulse, occurring after the final four 1s.
REQ-031 Long press (macro on): hold for 30 cycles -> exactly one long_o pulse 16 cycles after press_o, then one release_o; with the macro off, long_o stays 0.
REQ-032 Reset mid-debounce: reset_async low for 1 cycle at count 2 -> all outputs 0, and the press is accepted 2+DEBOUNCE_CYCLES edges after release.
REQ-033 Independence: both channels toggle on the same edge -> press_o=2'b11 in one cycle; channel 1 released 3 cycles early -> release_o[1] pulses alone.
